// File: rtl/data_memory_bytelane.sv
// Byte-lane data memory for RISC-V loads/stores; rd/rvalid/misalign appear one cycle after the accepting edge,
// one access per cycle, requests ignored only while busy (zero-fill after reset, enabled by DMEM_INIT_CLEAR_EN).
module data_memory_bytelane #(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [2:0]    funct3,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wd,
    output logic [31:0]   rd,
    output logic          rvalid,
    output logic          misalign,
    output logic          busy
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;
`ifdef DMEM_INIT_CLEAR_EN
    localparam logic [0:0] ST_RESET = ST_INIT;
`else
    localparam logic [0:0] ST_RESET = ST_IDLE;
`endif

    logic [0:0]    state_q, state_d;
    logic          acc, bad, size_bad;
    logic [IW-1:0] idx;
    logic [1:0]    off;
    logic [3:0]    be;
    logic [31:0]   wdat;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_dat;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   rdata_q;
    logic          pend_ld_q, pend_rej_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [31:0]   rd_q, rd_d;
    logic          rvalid_q, misalign_q;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic          addr_unused;

    // Address bits above the word index are ignored so accesses wrap modulo 4*DEPTH.
    assign addr_unused = ^addr[AW-1:IW+2];
    assign idx         = addr[IW+1:2];
    assign off         = addr[1:0];
    assign busy        = (state_q == ST_INIT);
    assign acc         = req & ~busy;

    assign rd       = rd_q;
    assign rvalid   = rvalid_q;
    assign misalign = misalign_q;

    always_comb begin
        case (funct3[1:0])
            2'b00:   size_bad = 1'b0;
            2'b01:   size_bad = off[0];
            2'b10:   size_bad = (off != 2'b00);
            default: size_bad = 1'b1;
        endcase
        bad = size_bad | (funct3 == 3'b110) | (we & funct3[2]);
    end

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                be   = 4'b0001 << off;
                wdat = {4{wd[7:0]}};
            end
            2'b01: begin
                be   = off[1] ? 4'b1100 : 4'b0011;
                wdat = {2{wd[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wdat = wd;
            end
        endcase
    end

`ifdef DMEM_INIT_CLEAR_EN
    logic [IW-1:0] clr_cnt_q, clr_cnt_d;

    // While clearing, the write port is owned by the clear counter; requests cannot be accepted then.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_en     = acc & we & ~bad;
        wr_idx    = idx;
        wr_be     = be;
        wr_dat    = wdat;
        if (state_q == ST_INIT) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            wr_en     = 1'b1;
            wr_idx    = clr_cnt_q;
            wr_be     = 4'b1111;
            wr_dat    = '0;
            if (clr_cnt_q == IW'(DEPTH - 1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end
`else
    always_comb begin
        state_d = ST_IDLE;
        wr_en   = acc & we & ~bad;
        wr_idx  = idx;
        wr_be   = be;
        wr_dat  = wdat;
    end
`endif

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (wr_en && wr_be[l]) begin
                mem_q[wr_idx][8*l +: 8] <= wr_dat[8*l +: 8];
            end
        end
        if (acc && !we) begin
            rdata_q <= mem_q[idx];
        end
    end

    always_comb begin
        case (off_q)
            2'b00:   ld_byte = rdata_q[7:0];
            2'b01:   ld_byte = rdata_q[15:8];
            2'b10:   ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        rd_d    = rd_q;
        if (pend_ld_q) begin
            if (pend_rej_q) begin
                rd_d = '0;
            end else begin
                case (f3_q)
                    3'b000:  rd_d = {{24{ld_byte[7]}}, ld_byte};
                    3'b001:  rd_d = {{16{ld_half[15]}}, ld_half};
                    3'b100:  rd_d = {24'b0, ld_byte};
                    3'b101:  rd_d = {16'b0, ld_half};
                    default: rd_d = rdata_q;
                endcase
            end
        end
    end

    // A pending load is dropped by reset, so no rvalid can follow it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RESET;
            pend_ld_q  <= 1'b0;
            pend_rej_q <= 1'b0;
            f3_q       <= 3'b0;
            off_q      <= 2'b0;
            rd_q       <= '0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_ld_q  <= acc & ~we;
            pend_rej_q <= acc & bad;
            if (acc) begin
                f3_q  <= funct3;
                off_q <= off;
            end
            rd_q       <= rd_d;
            rvalid_q   <= pend_ld_q;
            misalign_q <= pend_rej_q;
        end
    end
endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed vector bench for data_memory_bytelane (DEPTH=16); runs with or without DMEM_INIT_CLEAR_EN.
module tb_data_memory_bytelane;
    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wd;
    logic [31:0] rd;
    logic        rvalid, misalign, busy;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        bit          r;
        bit          w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        bit          ev;
        bit          em;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl[$];
    vec_t vq[$];

    data_memory_bytelane #(.DEPTH(16), .AW(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wd(wd), .rd(rd), .rvalid(rvalid), .misalign(misalign), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mk(bit r, bit w, logic [2:0] f3, logic [31:0] a, logic [31:0] d,
                                bit ev, bit em, logic [31:0] erd);
        vec_t v;
        v.r = r; v.w = w; v.f3 = f3; v.a = a; v.d = d; v.ev = ev; v.em = em; v.erd = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        req = v.r; we = v.w; funct3 = v.f3; addr = v.a; wd = v.d;
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0; funct3 = 3'b0; addr = 32'h0; wd = 32'h0;
    endtask

    task automatic check_row(input vec_t v, input int i);
        check($sformatf("row%0d rvalid", i), 32'(rvalid), 32'(v.ev));
        check($sformatf("row%0d misalign", i), 32'(misalign), 32'(v.em));
        if (v.ev) check($sformatf("row%0d rd", i), rd, v.erd);
    endtask

    // Rows are issued back to back; each row's results show up after the following edge.
    task automatic run_queue();
        for (int i = 0; i <= vq.size(); i++) begin
            if (i < vq.size()) drive(vq[i]);
            else idle();
            step();
            if (i > 0) check_row(vq[i-1], i - 1);
        end
        vq.delete();
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        while (busy && cnt < 200) begin
            step();
            cnt++;
        end
        check(name, 32'(cnt), 32'd16);
    endtask

    initial begin
        int  seen;
        int  cnt;

        tbl.push_back(mk(Y, Y, F_W,   32'h40, 32'h8899AABB, N, N, 32'h0));
        tbl.push_back(mk(Y, N, F_B,   32'h41, 32'h0, Y, N, 32'hFFFFFFAA));
        tbl.push_back(mk(Y, N, F_BU,  32'h43, 32'h0, Y, N, 32'h00000088));
        tbl.push_back(mk(Y, N, F_HU,  32'h42, 32'h0, Y, N, 32'h00008899));
        tbl.push_back(mk(Y, N, F_H,   32'h42, 32'h0, Y, N, 32'hFFFF8899));
        tbl.push_back(mk(Y, N, F_W,   32'h40, 32'h0, Y, N, 32'h8899AABB));
        tbl.push_back(mk(Y, Y, F_W,   32'h48, 32'h12345678, N, N, 32'h0));
        tbl.push_back(mk(Y, N, F_B,   32'h4B, 32'h0, Y, N, 32'h00000012));
        tbl.push_back(mk(Y, N, F_H,   32'h48, 32'h0, Y, N, 32'h00005678));
        tbl.push_back(mk(Y, N, F_BU,  32'h48, 32'h0, Y, N, 32'h00000078));
        tbl.push_back(mk(N, N, F_W,   32'h40, 32'h0, N, N, 32'h0));
        tbl.push_back(mk(Y, Y, F_W,   32'h40, 32'hFFFFFFFF, N, N, 32'h0));
        tbl.push_back(mk(Y, Y, F_H,   32'h42, 32'hAAAA1234, N, N, 32'h0));
        tbl.push_back(mk(Y, N, F_W,   32'h40, 32'h0, Y, N, 32'h1234FFFF));
        tbl.push_back(mk(Y, Y, F_B,   32'h40, 32'hFFFFFF7F, N, N, 32'h0));
        tbl.push_back(mk(Y, N, F_W,   32'h40, 32'h0, Y, N, 32'h1234FF7F));
        tbl.push_back(mk(Y, N, F_W,   32'h41, 32'h0, Y, Y, 32'h0));
        tbl.push_back(mk(Y, Y, F_H,   32'h43, 32'h0, N, Y, 32'h0));
        tbl.push_back(mk(Y, N, 3'b011, 32'h40, 32'h0, Y, Y, 32'h0));
        tbl.push_back(mk(Y, Y, F_W,   32'h42, 32'h0, N, Y, 32'h0));
        tbl.push_back(mk(Y, Y, F_BU,  32'h40, 32'h0, N, Y, 32'h0));
        tbl.push_back(mk(Y, N, F_H,   32'h41, 32'h0, Y, Y, 32'h0));
        tbl.push_back(mk(Y, Y, 3'b011, 32'h40, 32'h0, N, Y, 32'h0));
        tbl.push_back(mk(Y, N, 3'b110, 32'h40, 32'h0, Y, Y, 32'h0));
        tbl.push_back(mk(Y, N, F_W,   32'h40, 32'h0, Y, N, 32'h1234FF7F));
        tbl.push_back(mk(Y, Y, F_W,   32'h44, 32'hDEADBEEF, N, N, 32'h0));
        tbl.push_back(mk(Y, N, F_W,   32'h04, 32'h0, Y, N, 32'hDEADBEEF));
        tbl.push_back(mk(Y, N, F_W,   32'hFFFFFF44, 32'h0, Y, N, 32'hDEADBEEF));

        rst = 1'b0;
        idle();
        #12;
        check("reset rd", rd, 32'h0);
        check("reset rvalid", 32'(rvalid), 32'h0);
        check("reset misalign", 32'(misalign), 32'h0);
`ifdef DMEM_INIT_CLEAR_EN
        check("reset busy", 32'(busy), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        // A load held through clearing must be ignored.
        req = 1'b1; we = 1'b0; funct3 = F_W; addr = 32'h0;
        cnt = 0;
        seen = 0;
        while (busy && cnt < 200) begin
            step();
            cnt++;
            if (rvalid) seen = 1;
        end
        idle();
        check("busy cycles", 32'(cnt), 32'd16);
        step();
        if (rvalid) seen = 1;
        check("no rvalid while busy", 32'(seen), 32'h0);
        for (int w = 0; w < 16; w++) vq.push_back(mk(Y, N, F_W, 32'(w * 4), 32'h0, Y, N, 32'h0));
        run_queue();
`else
        check("reset busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("busy after release", 32'(busy), 32'h0);
`endif

        vq = tbl;
        run_queue();

        step();
        step();
        check("rd hold", rd, 32'hDEADBEEF);
        check("rvalid idle", 32'(rvalid), 32'h0);
        check("misalign idle", 32'(misalign), 32'h0);

        // Reset right after a load is accepted discards it.
        drive(mk(Y, N, F_W, 32'h44, 32'h0, Y, N, 32'h0));
        step();
        idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst rd", rd, 32'h0);
        check("rst rvalid", 32'(rvalid), 32'h0);
        step();
        check("rst rvalid held", 32'(rvalid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (rvalid) seen = 1;
        end
        check("no rvalid after rst", 32'(seen), 32'h0);
        check("rd after rst", rd, 32'h0);

`ifdef DMEM_INIT_CLEAR_EN
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("busy in mid-clear rst", 32'(busy), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        count_busy("busy cycles restart");
        vq.push_back(mk(Y, N, F_W, 32'h44, 32'h0, Y, N, 32'h0));
        run_queue();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
